vgaclk_prog: RTL

- Sequencer for the DCM_CLKGEN dynamic reprogramming port that generates the VGA pixel clock in the clock/reset generator.
- Accepts a new M/D pair from a CSR-side strobe and serialises LoadD, LoadM and GO onto PROGCLK/PROGEN/PROGDATA.
- Waits for PROGDONE, then for LOCKED, and reports done or error.
- Runs in the sys_clk domain; PROGCLK is a divided copy of sys_clk.

---
 rtl/vgaclk_prog.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vgaclk_prog.sv
// vgaclk_prog: sequencer for the DCM_CLKGEN dynamic reprogramming port.
// Serialises LoadD, LoadM and GO onto PROGCLK/PROGEN/PROGDATA, then waits
// for PROGDONE and LOCKED and reports done or an error code.
//
// Ports (all in the sys_clk domain unless noted):
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   start              one-cycle request, latches m_minus1 / d_minus1
//   m_minus1[7:0]      multiplier M-1 (1..255 legal)
//   d_minus1[7:0]      divider D-1 (0..255 legal)
//   busy               sequence in progress
//   done               one-cycle pulse on successful lock
//   err_code[1:0]      0 none, 1 bad M, 2 PROGDONE timeout, 3 lock timeout
//   prog_clk/en/data   to DCM PROGCLK / PROGEN / PROGDATA
//   prog_done, locked  from DCM, asynchronous, synchronised here
//   dcm_rst            to DCM RST
//
// Optional build macro VGACLK_PROG_AUTORESET_EN: on the first lock timeout
// of a sequence, pulse dcm_rst for 8 PROGCLK periods and retry the lock wait.
// Without it dcm_rst is tied low.

module vgaclk_prog #(
    parameter int PROG_HALF    = 4,
    parameter int DONE_TIMEOUT = 1024,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [7:0] m_minus1,
    input  logic [7:0] d_minus1,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code,
    output logic       prog_clk,
    output logic       prog_en,
    output logic       prog_data,
    input  logic       prog_done,
    input  logic       locked,
    output logic       dcm_rst
);

    localparam int DW = (PROG_HALF > 1) ? $clog2(PROG_HALF) : 1;
    localparam logic [DW-1:0] DIV_MAX  = DW'(PROG_HALF - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [15:0]   DONE_LIM = 16'(DONE_TIMEOUT - 1);
    localparam logic [15:0]   LOCK_LIM = 16'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_D,
        S_GAP1,
        S_LOAD_M,
        S_GAP2,
        S_GO,
        S_WAIT_DONE,
        S_WAIT_LOCK,
        S_RST_DCM
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          pclk_q, pclk_d;
    logic          en_q, en_d;
    logic          data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [7:0]    m_q, m_d;
    logic [8:0]    sh_q, sh_d;

    logic pd_s1_q, pd_s2_q, pd_s3_q;
    logic lk_s1_q, lk_s2_q;

`ifdef VGACLK_PROG_AUTORESET_EN
    logic dcmrst_q, dcmrst_d;
    logic retry_q, retry_d;
`endif

    logic        tick;
    logic        pd_rise;
    logic [15:0] cnt_inc;
    logic [15:0] cnt_sat;

    // A tick is the cycle whose edge drives prog_clk from 1 to 0.
    assign tick    = busy_q & pclk_q & (div_q == DIV_MAX);
    assign pd_rise = pd_s2_q & ~pd_s3_q;
    assign cnt_inc = cnt_q + 16'd1;
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pd_s1_q <= 1'b0;
            pd_s2_q <= 1'b0;
            pd_s3_q <= 1'b0;
            lk_s1_q <= 1'b0;
            lk_s2_q <= 1'b0;
        end else begin
            pd_s1_q <= prog_done;
            pd_s2_q <= pd_s1_q;
            pd_s3_q <= pd_s2_q;
            lk_s1_q <= locked;
            lk_s2_q <= lk_s1_q;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            pclk_q  <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 2'd0;
            m_q     <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            en_q    <= en_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            m_q     <= m_d;
            sh_q    <= sh_d;
        end
    end

`ifdef VGACLK_PROG_AUTORESET_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dcmrst_q <= 1'b0;
            retry_q  <= 1'b0;
        end else begin
            dcmrst_q <= dcmrst_d;
            retry_q  <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        m_d     = m_q;
        sh_d    = sh_q;
`ifdef VGACLK_PROG_AUTORESET_EN
        dcmrst_d = dcmrst_q;
        retry_d  = retry_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (m_minus1 == 8'd0) begin
                        err_d = 2'd1;
                    end else begin
                        // First LoadD bit goes out immediately so it is
                        // already stable at the first PROGCLK rise.
                        m_d     = m_minus1;
                        sh_d    = {d_minus1, 1'b0};
                        err_d   = 2'd0;
                        busy_d  = 1'b1;
                        state_d = S_LOAD_D;
                        cnt_d   = '0;
                        en_d    = 1'b1;
                        data_d  = 1'b1;
`ifdef VGACLK_PROG_AUTORESET_EN
                        retry_d = 1'b0;
`endif
                    end
                end
            end
            S_LOAD_D, S_LOAD_M: begin
                if (tick) begin
                    if (cnt_q == 16'd9) begin
                        state_d = (state_q == S_LOAD_D) ? S_GAP1 : S_GAP2;
                        cnt_d   = '0;
                        en_d    = 1'b0;
                        data_d  = 1'b0;
                    end else begin
                        cnt_d  = cnt_inc;
                        data_d = sh_q[0];
                        sh_d   = {1'b0, sh_q[8:1]};
                    end
                end
            end
            S_GAP1: begin
                if (tick) begin
                    if (cnt_q == 16'd1) begin
                        state_d = S_LOAD_M;
                        cnt_d   = '0;
                        en_d    = 1'b1;
                        data_d  = 1'b1;
                        sh_d    = {m_q, 1'b1};
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_GAP2: begin
                if (tick) begin
                    if (cnt_q == 16'd1) begin
                        state_d = S_GO;
                        cnt_d   = '0;
                        en_d    = 1'b1;
                        data_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_GO: begin
                if (tick) begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end
            end
            S_WAIT_DONE: begin
                // Edge checked first: it beats a timeout on the same tick.
                if (pd_rise) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q >= DONE_LIM) begin
                        err_d   = 2'd2;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
            end
            S_WAIT_LOCK: begin
                if (lk_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (cnt_q >= LOCK_LIM) begin
`ifdef VGACLK_PROG_AUTORESET_EN
                        if (!retry_q) begin
                            state_d  = S_RST_DCM;
                            cnt_d    = '0;
                            dcmrst_d = 1'b1;
                            retry_d  = 1'b1;
                        end else begin
                            err_d   = 2'd3;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
`else
                        err_d   = 2'd3;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
            end
`ifdef VGACLK_PROG_AUTORESET_EN
            S_RST_DCM: begin
                if (tick) begin
                    if (cnt_q == 16'd7) begin
                        state_d  = S_WAIT_LOCK;
                        cnt_d    = '0;
                        dcmrst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
                data_d  = 1'b0;
            end
        endcase
    end

    // Divider free-runs only while the sequence stays active; it restarts
    // from a low prog_clk on the next accepted start.
    always_comb begin
        div_d  = '0;
        pclk_d = 1'b0;
        if (busy_q && busy_d) begin
            if (div_q == DIV_MAX) begin
                pclk_d = ~pclk_q;
            end else begin
                div_d  = div_q + DIV_ONE;
                pclk_d = pclk_q;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_code  = err_q;
    assign prog_clk  = pclk_q;
    assign prog_en   = en_q;
    assign prog_data = data_q;

`ifdef VGACLK_PROG_AUTORESET_EN
    assign dcm_rst = dcmrst_q;
`else
    assign dcm_rst = 1'b0;
`endif

endmodule
